// File: rtl/pulse_period_meter.sv
// Measures clock cycles between successive rising edges of pulse_in and offers them on a
// valid/ready output. Define PERIOD_METER_MINMAX_EN to track min/max captured periods.
module pulse_period_meter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             pulse_in,
  input  logic             period_ready,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             missed,
  output logic [WIDTH-1:0] min_period,
  output logic [WIDTH-1:0] max_period
);

  localparam logic [WIDTH-1:0] CountMax = '1;
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StMeasure
  } state_e;

  state_e           state_q, state_d;
  logic             pulse_d;
  logic             pulse_edge;
  logic             capture;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             missed_q, missed_d;

  assign pulse_edge = pulse_in & ~pulse_d;

  // Edge history is kept in every state so a level already high on arming is not an edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pulse_d <= 1'b0;
    end else begin
      pulse_d <= pulse_in;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArmed;
        end
        StArmed: begin
          if (pulse_edge) begin
            state_d = StMeasure;
            count_d = CountOne;
          end
        end
        StMeasure: begin
          if (pulse_edge) begin
            capture = 1'b1;
            count_d = CountOne;
          end else if (count_q != CountMax) begin
            count_d = count_q + CountOne;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    period_d = capture ? count_q : period_q;

    if (!enable) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // Set events take precedence over a same-cycle clear.
    if (capture && (count_q == CountMax)) begin
      overflow_d = 1'b1;
    end else if (clear_flags) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (capture && valid_q && !period_ready) begin
      missed_d = 1'b1;
    end else if (clear_flags) begin
      missed_d = 1'b0;
    end else begin
      missed_d = missed_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      count_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      missed_q   <= missed_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = overflow_q;
  assign missed       = missed_q;

`ifdef PERIOD_METER_MINMAX_EN
  logic             reload;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  // Trackers restart on every new arming and on clear; a same-cycle capture folds in after.
  assign reload = clear_flags || (enable && (state_q == StIdle));

  always_comb begin
    min_d = reload ? CountMax : min_q;
    max_d = reload ? '0 : max_q;
    if (capture) begin
      if (count_q < min_d) begin
        min_d = count_q;
      end
      if (count_q > max_d) begin
        max_d = count_q;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      min_q <= CountMax;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`else
  assign min_period = '0;
  assign max_period = '0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomized bench for pulse_period_meter: an interval-based reference model feeds a
// scoreboard queue that a negedge monitor drains on every accepted measurement.
module tb_pulse_period_meter;

  localparam int unsigned W      = 8;
  localparam int unsigned MaxCnt = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         resetn;
  logic         enable;
  logic         pulse_in;
  logic         period_ready;
  logic         clear_flags;
  logic [W-1:0] period;
  logic         period_valid;
  logic         overflow;
  logic         missed;
  logic [W-1:0] min_period;
  logic [W-1:0] max_period;

  pulse_period_meter #(.WIDTH(W)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .pulse_in    (pulse_in),
    .period_ready(period_ready),
    .clear_flags (clear_flags),
    .period      (period),
    .period_valid(period_valid),
    .overflow    (overflow),
    .missed      (missed),
    .min_period  (min_period),
    .max_period  (max_period)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;
  bit started = 1'b0;

  // Reference model: phase 0 idle, 1 waiting for first edge, 2 timing from last_edge.
  int unsigned q[$];
  int          phase;
  longint      cyc;
  longint      last_edge;
  bit          m_prev;
  bit          m_ovf;
  bit          m_missed;
  int unsigned m_period;
  int unsigned m_min;
  int unsigned m_max;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    phase    = 0;
    m_prev   = 1'b0;
    m_ovf    = 1'b0;
    m_missed = 1'b0;
    m_period = 0;
    m_min    = MaxCnt;
    m_max    = 0;
  endtask

  // Called at each rising edge with the inputs that edge samples.
  task automatic model_step();
    bit          edge_seen;
    bit          cap;
    bit          reload;
    bit          set_ovf;
    bit          set_miss;
    int unsigned per;
    longint      n;
    cyc++;
    if (!resetn) begin
      model_reset();
      return;
    end
    edge_seen = pulse_in && !m_prev;
    m_prev    = pulse_in;
    cap       = 1'b0;
    reload    = 1'b0;
    per       = 0;
    if (!enable) begin
      phase = 0;
      q.delete();
    end else begin
      case (phase)
        0: begin
          phase  = 1;
          reload = 1'b1;
        end
        1: if (edge_seen) begin
          phase     = 2;
          last_edge = cyc;
        end
        default: if (edge_seen) begin
          n         = cyc - last_edge;
          per       = (n > MaxCnt) ? MaxCnt : int'(n);
          cap       = 1'b1;
          last_edge = cyc;
        end
      endcase
    end
    // An entry still queued here was not accepted before this edge.
    set_ovf  = cap && (per == MaxCnt);
    set_miss = cap && (q.size() != 0);
    if (cap) begin
      m_period = per;
      if (q.size() != 0) q[0] = per;
      else q.push_back(per);
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clear_flags) m_ovf = 1'b0;
    if (set_miss) m_missed = 1'b1;
    else if (clear_flags) m_missed = 1'b0;
    if (reload || clear_flags) begin
      m_min = MaxCnt;
      m_max = 0;
    end
    if (cap) begin
      if (per < m_min) m_min = per;
      if (per > m_max) m_max = per;
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      check("valid", period_valid, q.size() != 0);
      if ((q.size() != 0) && period_ready) begin
        int unsigned exp_per;
        exp_per = q.pop_front();
        check("accepted_period", period, exp_per);
      end
      check("period", period, m_period);
      check("overflow", overflow, m_ovf);
      check("missed", missed, m_missed);
`ifdef PERIOD_METER_MINMAX_EN
      check("min_period", min_period, m_min);
      check("max_period", max_period, m_max);
`else
      check("min_period", min_period, 0);
      check("max_period", max_period, 0);
`endif
    end
  end

  initial begin
    int unsigned per_len;
    int unsigned high_len;
    int unsigned ph;
    int unsigned mode;
    int unsigned rdy_mode;
    int unsigned seg_len;
    int unsigned en_low;

    cyc          = 0;
    last_edge    = 0;
    resetn       = 1'b0;
    enable       = 1'b0;
    pulse_in     = 1'b0;
    period_ready = 1'b0;
    clear_flags  = 1'b0;
    model_reset();
    started = 1'b1;
    repeat (2) begin
      @(posedge clock);
      model_step();
    end
    en_low = 0;
    ph     = 0;

    for (int seg = 0; seg < 40; seg++) begin
      mode     = $urandom_range(0, 3);
      rdy_mode = $urandom_range(0, 2);
      per_len  = (mode == 3) ? $urandom_range(250, 300) : $urandom_range(2, 20);
      high_len = $urandom_range(1, per_len - 1);
      seg_len  = (mode == 3) ? 1200 : 160;
      for (int c = 0; c < int'(seg_len); c++) begin
        #1;
        if (!resetn) begin
          resetn = 1'b1;
        end else if ($urandom_range(0, 499) == 0) begin
          resetn = 1'b0;
          model_reset();
        end
        if (en_low != 0) begin
          en_low--;
          enable = 1'b0;
        end else if ($urandom_range(0, 149) == 0) begin
          en_low = $urandom_range(0, 2);
          enable = 1'b0;
        end else begin
          enable = 1'b1;
        end
        if (mode == 0) begin
          pulse_in = ($urandom_range(0, 3) == 0);
        end else begin
          ph       = (ph + 1) % per_len;
          pulse_in = (ph < high_len);
        end
        case (rdy_mode)
          0:       period_ready = 1'b1;
          1:       period_ready = $urandom_range(0, 1) == 1;
          default: period_ready = ($urandom_range(0, 9) == 0);
        endcase
        clear_flags = ($urandom_range(0, 59) == 0);
        @(posedge clock);
        model_step();
      end
    end

    #1;
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter WIDTH, default 32, counter and period width in bits.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  measurement enable; low forces IDLE.
REQ-005 pulse_in  input  1  synchronous pulse stream, e.g. a rate-divider out_pulse; only rising edges count.
REQ-006 period_ready  input  1  consumer accepts period when high with period_valid.
REQ-007 clear_flags  input  1  one-cycle clear of overflow, missed and min/max trackers.
REQ-008 period  output  WIDTH  clock cycles between the last two pulse_in rising edges.
REQ-009 period_valid  output  1  period holds an unconsumed measurement.
REQ-010 overflow  output  1  sticky; an interval reached saturation.
REQ-011 missed  output  1  sticky; a measurement was overwritten before acceptance.
REQ-012 min_period, max_period  output  WIDTH each  extremes of captured periods (see Configuration).

Function
REQ-013 Edge detect: edge = pulse_in & ~pulse_d, where pulse_d is pulse_in registered every cycle regardless of state; a multi-cycle high level yields one edge.
REQ-014 States IDLE, ARMED, MEASURE; IDLE->ARMED when enable=1; ARMED->MEASURE on edge; any state->IDLE when enable=0 (takes priority over edge).
REQ-015 An edge in IDLE is ignored; the first edge in ARMED starts timing but produces no measurement.
REQ-016 On entering MEASURE and on every edge in MEASURE, count loads 1; otherwise count increments by 1 per cycle.
REQ-017 count saturates at 2^WIDTH-1, never wraps.
REQ-018 On edge in MEASURE, period <= count, period_valid <= 1; edges N cycles apart give period=N; latency: period/period_valid update on the same clock edge that samples the edge.
REQ-019 If the captured count equals 2^WIDTH-1, overflow <= 1.
REQ-020 period_valid clears on a clock edge with period_valid=1 and period_ready=1, unless a new capture occurs on that edge, in which case it stays 1 with the new value and missed is not set.
REQ-021 Capture while period_valid=1 and period_ready=0: period overwritten, missed <= 1.
REQ-022 enable=0: count <= 0, period_valid <= 0; period, overflow, missed retained.
REQ-023 clear_flags=1: overflow, missed <= 0 on that edge; a same-cycle set event wins over the clear.
REQ-024 period is stable while period_valid=1 except per REQ-020/REQ-021.

Reset
REQ-025 resetn=0 immediately forces state IDLE, count=0, pulse_d=0, period=0, period_valid=0, overflow=0, missed=0, min_period=all-ones, max_period=0.
REQ-026 Reset mid-measurement discards the partial interval; first edge after reset release and enable is treated per REQ-015.

Configuration
REQ-027 Macro PERIOD_METER_MINMAX_EN defined: each capture updates min_period and max_period to the min/max of themselves and the new period; reload to all-ones and 0 on clear_flags and on IDLE->ARMED.
REQ-028 Macro not defined: min_period and max_period ports present, tied to 0, no tracking logic.

Verification
REQ-029 enable=1, single-cycle pulse_in every 5 cycles, period_ready=1 -> first edge no output; each subsequent edge period=5, period_valid high exactly 1 cycle.
REQ-030 WIDTH=4, edges 20 cycles apart -> period=15, overflow=1; clear_flags pulse -> overflow=0.
REQ-031 period_ready=0, edges every 3 then every 7 cycles -> period=7, period_valid=1, missed=1; period_ready=1 one cycle -> period_valid=0.
REQ-032 pulse_in held high 4 cycles, low 6, repeating -> period=10 per edge.
REQ-033 resetn low mid-interval and enable toggled low mid-interval -> all outputs per REQ-025/REQ-022; first following edge no measurement.
REQ-034 MINMAX_EN defined, periods 8,3,12 -> min_period=3, max_period=12; undefined -> both 0.
